// File: rtl/vend_txn_ctrl_if.sv
// -----------------------------------------------------------------------------
// vend_txn_ctrl_if
// Link between the vending transaction sequencer and the coin_return block.
//   money/price : amount tendered and amount kept (cents, 9-bit unsigned)
//   start       : one-cycle launch pulse for a change/refund operation
//   done        : coin_return has finished paying out
//   disp_*      : one pulse per coin ejected, by denomination
//   avail_*     : denomination has stock (inventory count != 0)
// Modports: master = sequencer side, slave = coin_return side.
// -----------------------------------------------------------------------------
interface vend_txn_ctrl_if;
    logic [8:0] money;
    logic [8:0] price;
    logic       start;
    logic       done;
    logic       disp_B, disp_Q, disp_D, disp_N, disp_P;
    logic       avail_B, avail_Q, avail_D, avail_N, avail_P;

    modport master (
        output money, price, start,
        output avail_B, avail_Q, avail_D, avail_N, avail_P,
        input  done,
        input  disp_B, disp_Q, disp_D, disp_N, disp_P
    );

    modport slave (
        input  money, price, start,
        input  avail_B, avail_Q, avail_D, avail_N, avail_P,
        output done,
        output disp_B, disp_Q, disp_D, disp_N, disp_P
    );
endinterface

// File: rtl/vend_txn_ctrl.sv
// -----------------------------------------------------------------------------
// vend_txn_ctrl
// Vending transaction sequencer in front of coin_return. Accumulates credit
// from the coin acceptor, checks selections against a fixed price table,
// pulses a product dispense, then launches coin_return for change or refund
// and waits for it to finish. Keeps a per-denomination coin inventory that
// drives coin_return's avail_* inputs.
// Ports:
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   coin_valid/type     : coin strobe, 0=B(100) 1=Q(25) 2=D(10) 3=N(5) 4=P(1)
//   sel_valid/sel_id    : product select strobe and index
//   cancel              : refund request
//   link (master)       : money/price/start/avail_* out, done/disp_* in
//   credit              : current accumulated credit
//   vend/vend_id        : product dispense pulse and index
//   coin_reject         : inserted coin returned to customer
//   err_funds           : selection rejected for insufficient credit
//   busy                : transaction in progress (VEND/CHG_START/CHG_WAIT)
//   fault               : sticky done-timeout or inventory underflow
// -----------------------------------------------------------------------------
module vend_txn_ctrl #(
    parameter logic [8:0]   PRICE0      = 9'd100,
    parameter logic [8:0]   PRICE1      = 9'd125,
    parameter logic [8:0]   PRICE2      = 9'd65,
    parameter logic [8:0]   PRICE3      = 9'd185,
    parameter logic [8:0]   MAX_CREDIT  = 9'd500,
    parameter int           CNT_W       = 6,
    parameter logic [CNT_W-1:0] INIT_CNT = CNT_W'(4),
    parameter int           TIMEOUT_CYC = 2000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  coin_valid,
    input  logic [2:0]            coin_type,
    input  logic                  sel_valid,
    input  logic [1:0]            sel_id,
    input  logic                  cancel,
    vend_txn_ctrl_if.master       link,
    output logic [8:0]            credit,
    output logic                  vend,
    output logic [1:0]            vend_id,
    output logic                  coin_reject,
    output logic                  err_funds,
    output logic                  busy,
    output logic                  fault
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int N_DEN = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CREDIT    = 3'd1,
        VEND      = 3'd2,
        CHG_START = 3'd3,
        CHG_WAIT  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [8:0]        credit_q, credit_d;
    logic [8:0]        money_q, money_d;
    logic [8:0]        price_q, price_d;
    logic              start_q, start_d;
    logic              vend_q, vend_d;
    logic [1:0]        vend_id_q, vend_id_d;
    logic              coin_reject_q, coin_reject_d;
    logic              err_funds_q, err_funds_d;
    logic              fault_q, fault_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [CNT_W-1:0]  cnt_q [N_DEN];
    logic [CNT_W-1:0]  cnt_d [N_DEN];
    logic [N_DEN-1:0]  disp_vec;
    logic [N_DEN-1:0]  uflow;
    logic              coin_acc;

    logic [6:0]        coin_value;
    logic              coin_ok;
    logic [9:0]        coin_sum;
    logic [8:0]        sel_price;

    always_comb begin
        coin_value = 7'd0;
        unique case (coin_type)
            3'd0:    coin_value = 7'd100;
            3'd1:    coin_value = 7'd25;
            3'd2:    coin_value = 7'd10;
            3'd3:    coin_value = 7'd5;
            3'd4:    coin_value = 7'd1;
            default: coin_value = 7'd0;
        endcase
    end

    assign coin_ok  = (coin_type <= 3'd4);
    // Sum is one bit wider than credit so an overflowing coin is caught
    // by the MAX_CREDIT compare rather than wrapping.
    assign coin_sum = {1'b0, credit_q} + {3'b000, coin_value};

    always_comb begin
        sel_price = PRICE0;
        unique case (sel_id)
            2'd0: sel_price = PRICE0;
            2'd1: sel_price = PRICE1;
            2'd2: sel_price = PRICE2;
            2'd3: sel_price = PRICE3;
            default: sel_price = PRICE0;
        endcase
    end

    // Transaction FSM: next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        money_d       = money_q;
        price_d       = price_q;
        start_d       = 1'b0;
        vend_d        = 1'b0;
        vend_id_d     = vend_id_q;
        coin_reject_d = 1'b0;
        err_funds_d   = 1'b0;
        tmo_d         = tmo_q;
        fault_d       = fault_q | (|uflow);
        coin_acc      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (coin_valid) begin
                    if (coin_ok) begin
                        credit_d = {2'b00, coin_value};
                        coin_acc = 1'b1;
                        state_d  = CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                if (sel_valid) begin
                    err_funds_d = 1'b1;
                end
            end

            CREDIT: begin
                // Priority cancel > select > coin; a coin that loses is returned.
                if (cancel) begin
                    money_d       = credit_q;
                    price_d       = 9'd0;
                    start_d       = 1'b1;
                    state_d       = CHG_START;
                    coin_reject_d = coin_valid;
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (credit_q >= sel_price) begin
                        money_d   = credit_q;
                        price_d   = sel_price;
                        vend_d    = 1'b1;
                        vend_id_d = sel_id;
                        state_d   = VEND;
                    end else begin
                        err_funds_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_ok && (coin_sum <= {1'b0, MAX_CREDIT})) begin
                        credit_d = coin_sum[8:0];
                        coin_acc = 1'b1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            VEND: begin
                coin_reject_d = coin_valid;
                if (money_q != price_q) begin
                    start_d = 1'b1;
                    state_d = CHG_START;
                end else begin
                    credit_d = 9'd0;
                    money_d  = 9'd0;
                    price_d  = 9'd0;
                    state_d  = IDLE;
                end
            end

            CHG_START: begin
                coin_reject_d = coin_valid;
                tmo_d         = '0;
                state_d       = CHG_WAIT;
            end

            CHG_WAIT: begin
                coin_reject_d = coin_valid;
                if (link.done) begin
                    credit_d = 9'd0;
                    money_d  = 9'd0;
                    price_d  = 9'd0;
                    state_d  = IDLE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    fault_d  = 1'b1;
                    credit_d = 9'd0;
                    money_d  = 9'd0;
                    price_d  = 9'd0;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Inventory: index 0=B .. 4=P, matching coin_type encoding.
    assign disp_vec = {link.disp_P, link.disp_N, link.disp_D, link.disp_Q, link.disp_B};

    generate
        for (genvar gi = 0; gi < N_DEN; gi++) begin : g_inv
            logic inc, dec;
            assign inc = coin_acc && (coin_type == 3'(gi));
            assign dec = disp_vec[gi];
            // Simultaneous coin-in and coin-out of one denomination cancel.
            assign uflow[gi] = dec && !inc && (cnt_q[gi] == '0);
            assign cnt_d[gi] = (inc && !dec && (cnt_q[gi] != CNT_MAX)) ? cnt_q[gi] + CNT_W'(1) :
                               (dec && !inc && (cnt_q[gi] != '0))      ? cnt_q[gi] - CNT_W'(1) :
                                                                          cnt_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= 9'd0;
            money_q       <= 9'd0;
            price_q       <= 9'd0;
            start_q       <= 1'b0;
            vend_q        <= 1'b0;
            vend_id_q     <= 2'd0;
            coin_reject_q <= 1'b0;
            err_funds_q   <= 1'b0;
            fault_q       <= 1'b0;
            tmo_q         <= '0;
            for (int i = 0; i < N_DEN; i++) begin
                cnt_q[i] <= INIT_CNT;
            end
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            money_q       <= money_d;
            price_q       <= price_d;
            start_q       <= start_d;
            vend_q        <= vend_d;
            vend_id_q     <= vend_id_d;
            coin_reject_q <= coin_reject_d;
            err_funds_q   <= err_funds_d;
            fault_q       <= fault_d;
            tmo_q         <= tmo_d;
            for (int i = 0; i < N_DEN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign link.money   = money_q;
    assign link.price   = price_q;
    assign link.start   = start_q;
    // avail_* come straight from registered counts, so they are stable
    // throughout the start pulse.
    assign link.avail_B = (cnt_q[0] != '0);
    assign link.avail_Q = (cnt_q[1] != '0);
    assign link.avail_D = (cnt_q[2] != '0);
    assign link.avail_N = (cnt_q[3] != '0);
    assign link.avail_P = (cnt_q[4] != '0);

    assign credit      = credit_q;
    assign vend        = vend_q;
    assign vend_id     = vend_id_q;
    assign coin_reject = coin_reject_q;
    assign err_funds   = err_funds_q;
    assign fault       = fault_q;
    assign busy        = (state_q == VEND) || (state_q == CHG_START) || (state_q == CHG_WAIT);

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_txn_ctrl
// Directed bench for vend_txn_ctrl. The bench plays both customer and
// coin_return; expected values are hand-computed from the price table and
// coin values. Inputs change 1ns after the rising edge, outputs are read
// at that same point (after registered updates have settled).
// -----------------------------------------------------------------------------
module tb_vend_txn_ctrl;

    localparam int TIMEOUT_CYC = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [2:0] coin_type = 3'd0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'd0;
    logic       cancel = 1'b0;
    logic [8:0] credit;
    logic       vend;
    logic [1:0] vend_id;
    logic       coin_reject;
    logic       err_funds;
    logic       busy;
    logic       fault;

    int n_vec  = 0;
    int n_miss = 0;

    vend_txn_ctrl_if link ();

    vend_txn_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .sel_valid   (sel_valid),
        .sel_id      (sel_id),
        .cancel      (cancel),
        .link        (link),
        .credit      (credit),
        .vend        (vend),
        .vend_id     (vend_id),
        .coin_reject (coin_reject),
        .err_funds   (err_funds),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_coin(input logic [2:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic do_sel(input logic [1:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    // k: 0=B 1=Q 2=D 3=N 4=P
    task automatic do_disp(input int k);
        case (k)
            0: link.disp_B = 1'b1;
            1: link.disp_Q = 1'b1;
            2: link.disp_D = 1'b1;
            3: link.disp_N = 1'b1;
            default: link.disp_P = 1'b1;
        endcase
        tick();
        link.disp_B = 1'b0;
        link.disp_Q = 1'b0;
        link.disp_D = 1'b0;
        link.disp_N = 1'b0;
        link.disp_P = 1'b0;
    endtask

    task automatic do_done();
        link.done = 1'b1;
        tick();
        link.done = 1'b0;
    endtask

    task automatic check_cnts(input string tag, input int b, input int q,
                              input int d, input int n, input int p);
        check({tag, " cntB"}, 32'(dut.cnt_q[0]), 32'(b));
        check({tag, " cntQ"}, 32'(dut.cnt_q[1]), 32'(q));
        check({tag, " cntD"}, 32'(dut.cnt_q[2]), 32'(d));
        check({tag, " cntN"}, 32'(dut.cnt_q[3]), 32'(n));
        check({tag, " cntP"}, 32'(dut.cnt_q[4]), 32'(p));
    endtask

    initial begin
        link.done   = 1'b0;
        link.disp_B = 1'b0;
        link.disp_Q = 1'b0;
        link.disp_D = 1'b0;
        link.disp_N = 1'b0;
        link.disp_P = 1'b0;

        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst credit", 32'(credit), 0);
        check("rst money", 32'(link.money), 0);
        check("rst start", 32'(link.start), 0);
        check("rst fault", 32'(fault), 0);
        check("rst busy", 32'(busy), 0);
        check("rst availB", 32'(link.avail_B), 1);
        check_cnts("rst", 4, 4, 4, 4, 4);

        // T1: B, B, Q -> 225, buy product 3 (185), change 40 = Q+D+N
        do_coin(3'd0); check("t1 credit1", 32'(credit), 100);
        do_coin(3'd0); check("t1 credit2", 32'(credit), 200);
        do_coin(3'd1); check("t1 credit3", 32'(credit), 225);
        do_sel(2'd3);
        check("t1 vend", 32'(vend), 1);
        check("t1 vend_id", 32'(vend_id), 3);
        check("t1 busy", 32'(busy), 1);
        check("t1 start early", 32'(link.start), 0);
        tick();
        check("t1 start", 32'(link.start), 1);
        check("t1 vend off", 32'(vend), 0);
        check("t1 money", 32'(link.money), 225);
        check("t1 price", 32'(link.price), 185);
        tick();
        check("t1 start off", 32'(link.start), 0);
        do_disp(1);
        do_disp(2);
        do_disp(3);
        do_done();
        check("t1 credit end", 32'(credit), 0);
        check("t1 money end", 32'(link.money), 0);
        check("t1 busy end", 32'(busy), 0);
        check_cnts("t1", 6, 4, 3, 3, 4);

        // T2: Q, D -> 35, select 0 rejected, then cancel; coin_return
        // drains all nickels and pennies during the refund.
        do_coin(3'd1);
        do_coin(3'd2); check("t2 credit", 32'(credit), 35);
        do_sel(2'd0);
        check("t2 err_funds", 32'(err_funds), 1);
        check("t2 credit hold", 32'(credit), 35);
        check("t2 no vend", 32'(vend), 0);
        do_cancel();
        check("t2 start", 32'(link.start), 1);
        check("t2 money", 32'(link.money), 35);
        check("t2 price", 32'(link.price), 0);
        check("t2 no vend2", 32'(vend), 0);
        tick();
        for (int i = 0; i < 3; i++) do_disp(3);
        for (int i = 0; i < 4; i++) do_disp(4);
        do_done();
        check("t2 availN", 32'(link.avail_N), 0);
        check("t2 availP", 32'(link.avail_P), 0);
        check("t2 credit end", 32'(credit), 0);
        check_cnts("t2", 6, 5, 4, 0, 0);

        // T3: 5 B = 500, sixth B overflows, invalid coin type 6
        for (int i = 0; i < 5; i++) do_coin(3'd0);
        check("t3 credit max", 32'(credit), 500);
        do_coin(3'd0);
        check("t3 reject ovf", 32'(coin_reject), 1);
        check("t3 credit hold", 32'(credit), 500);
        check("t3 cntB", 32'(dut.cnt_q[0]), 11);
        do_coin(3'd6);
        check("t3 reject bad", 32'(coin_reject), 1);
        check("t3 credit hold2", 32'(credit), 500);
        do_cancel();
        check("t3 refund money", 32'(link.money), 500);
        tick();
        do_done();
        check("t3 credit end", 32'(credit), 0);

        // T4: B, then select 0 together with a coin: exact price, coin loses
        do_coin(3'd0);
        coin_valid = 1'b1; coin_type = 3'd0;
        sel_valid  = 1'b1; sel_id    = 2'd0;
        tick();
        coin_valid = 1'b0; sel_valid = 1'b0;
        check("t4 vend", 32'(vend), 1);
        check("t4 vend_id", 32'(vend_id), 0);
        check("t4 reject", 32'(coin_reject), 1);
        check("t4 cntB", 32'(dut.cnt_q[0]), 12);
        tick();
        check("t4 no start", 32'(link.start), 0);
        check("t4 credit", 32'(credit), 0);
        check("t4 busy", 32'(busy), 0);

        // T5: no nickels/pennies in stock, buy product 2 (65) with 135
        do_coin(3'd1);
        do_coin(3'd2);
        do_sel(2'd2);
        check("t5 err_funds", 32'(err_funds), 1);
        do_coin(3'd0);
        check("t5 credit", 32'(credit), 135);
        do_sel(2'd2);
        check("t5 vend_id", 32'(vend_id), 2);
        tick();
        check("t5 start", 32'(link.start), 1);
        check("t5 money", 32'(link.money), 135);
        check("t5 price", 32'(link.price), 65);
        check("t5 availN", 32'(link.avail_N), 0);
        check("t5 availP", 32'(link.avail_P), 0);
        check("t5 availD", 32'(link.avail_D), 1);
        tick();
        do_disp(1);
        do_disp(1);
        do_disp(2); check("t5 cntD a", 32'(dut.cnt_q[2]), 4);
        do_disp(2); check("t5 cntD b", 32'(dut.cnt_q[2]), 3);
        do_done();
        check("t5 credit end", 32'(credit), 0);
        check_cnts("t5", 13, 4, 3, 0, 0);

        // T6: done never comes -> timeout fault
        do_coin(3'd0);
        do_cancel();
        check("t6 start", 32'(link.start), 1);
        for (int i = 0; i < TIMEOUT_CYC - 10; i++) tick();
        check("t6 no fault yet", 32'(fault), 0);
        check("t6 still busy", 32'(busy), 1);
        for (int i = 0; i < 30 && !fault; i++) tick();
        check("t6 fault", 32'(fault), 1);
        check("t6 credit", 32'(credit), 0);
        check("t6 busy", 32'(busy), 0);

        // Reset mid-CHG_WAIT on a new transaction
        do_coin(3'd0);
        check("t6b credit", 32'(credit), 100);
        do_cancel();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6b start", 32'(link.start), 0);
        check("t6b fault", 32'(fault), 0);
        check("t6b credit", 32'(credit), 0);
        check("t6b busy", 32'(busy), 0);
        check_cnts("t6b", 4, 4, 4, 4, 4);

        // T7: inventory underflow on pennies sets fault
        do_coin(3'd0);
        do_cancel();
        tick();
        for (int i = 0; i < 4; i++) do_disp(4);
        check("t7 cntP zero", 32'(dut.cnt_q[4]), 0);
        check("t7 no fault", 32'(fault), 0);
        do_disp(4);
        check("t7 cntP hold", 32'(dut.cnt_q[4]), 0);
        check("t7 fault", 32'(fault), 1);
        do_done();
        check("t7 busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
